// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - instruction bus responder wrapping a word-addressed SRAM
module instr_mem_responder #(
   parameter int          DepthWords = 4096,
   parameter logic [31:0] BaseAddr   = 32'h0000_0000,
   parameter int          Latency    = 1,
   parameter int          WaitStates = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          instr_req_i,
   input  logic [31:0]                   instr_addr_i,
   output logic                          instr_gnt_o,
   output logic                          instr_rvalid_o,
   output logic [31:0]                   instr_rdata_o,
   output logic                          instr_err_o,
   input  logic                          ld_we_i,
   input  logic [$clog2(DepthWords)-1:0] ld_addr_i,
   input  logic [31:0]                   ld_wdata_i,
   output logic                          busy_o
);

   localparam int          AW    = $clog2(DepthWords);
   localparam logic [2:0]  WS    = 3'(WaitStates);
   localparam logic [32:0] LIMIT = 33'(DepthWords) << 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic [31:0]        mem [DepthWords];
   logic [2:0]         wait_cnt;
   logic [31:0]        off;
   logic               in_range;
   logic [AW-1:0]      idx;
   logic               gnt;
   logic [Latency-1:0] valid_q;
   logic [Latency-1:0] err_q;
   logic [31:0]        data_q [Latency];

   // Decode the request address relative to the base; below-base addresses wrap high and fail.
   always_comb begin
      off      = instr_addr_i - BaseAddr;
      in_range = ({1'b0, off} < LIMIT);
      idx      = off[AW+1:2];
      gnt      = rst_n & instr_req_i & ~ld_we_i & (wait_cnt == WS);
   end

   assign instr_gnt_o = gnt;

   // Wait-state counter: saturates while a request waits, holds during loader writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 3'd0;
      end else if (!ld_we_i) begin
         if (!instr_req_i || gnt) begin
            wait_cnt <= 3'd0;
         end else if (wait_cnt != WS) begin
            wait_cnt <= wait_cnt + 3'd1;
         end
      end
   end

   // Response control pipeline: one {valid, err} pair per latency stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         err_q   <= '0;
      end else begin
         valid_q[0] <= gnt;
         err_q[0]   <= gnt & ~in_range;
         for (int i = 1; i < Latency; i++) begin
            valid_q[i] <= valid_q[i-1];
            err_q[i]   <= err_q[i-1];
         end
      end
   end

   // SRAM: loader write, synchronous read only for in-range grants, then data delay stages.
   always_ff @(posedge clk) begin
      if (ld_we_i) begin
         mem[ld_addr_i] <= ld_wdata_i;
      end
      if (gnt && in_range) begin
         data_q[0] <= mem[idx];
      end
      for (int i = 1; i < Latency; i++) begin
         data_q[i] <= data_q[i-1];
      end
   end

   // Output stage: data and err are forced to zero whenever no response is presented.
   always_comb begin
      instr_rvalid_o = valid_q[Latency-1];
      instr_err_o    = valid_q[Latency-1] & err_q[Latency-1];
      instr_rdata_o  = 32'h0;
      if (valid_q[Latency-1]) begin
         instr_rdata_o = err_q[Latency-1] ? NOP : data_q[Latency-1];
      end
      busy_o = |valid_q;
   end

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - directed self-checking bench for instr_mem_responder
module tb_instr_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic [31:0] addr;
   logic        ld_we;
   logic [11:0] ld_addr;
   logic [31:0] ld_wdata;

   // a: L1/WS0, b: L1/WS2, c: L3/WS0, d: L2/WS0 ; all share the same inputs
   logic gnt_a, rv_a, err_a, busy_a; logic [31:0] rd_a;
   logic gnt_b, rv_b, err_b, busy_b; logic [31:0] rd_b;
   logic gnt_c, rv_c, err_c, busy_c; logic [31:0] rd_c;
   logic gnt_d, rv_d, err_d, busy_d; logic [31:0] rd_d;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_mem_responder #(.Latency(1), .WaitStates(0)) u_a (
      .clk(clk), .rst_n(rst_n), .instr_req_i(req), .instr_addr_i(addr),
      .instr_gnt_o(gnt_a), .instr_rvalid_o(rv_a), .instr_rdata_o(rd_a), .instr_err_o(err_a),
      .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata), .busy_o(busy_a));

   instr_mem_responder #(.Latency(1), .WaitStates(2)) u_b (
      .clk(clk), .rst_n(rst_n), .instr_req_i(req), .instr_addr_i(addr),
      .instr_gnt_o(gnt_b), .instr_rvalid_o(rv_b), .instr_rdata_o(rd_b), .instr_err_o(err_b),
      .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata), .busy_o(busy_b));

   instr_mem_responder #(.Latency(3), .WaitStates(0)) u_c (
      .clk(clk), .rst_n(rst_n), .instr_req_i(req), .instr_addr_i(addr),
      .instr_gnt_o(gnt_c), .instr_rvalid_o(rv_c), .instr_rdata_o(rd_c), .instr_err_o(err_c),
      .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata), .busy_o(busy_c));

   instr_mem_responder #(.Latency(2), .WaitStates(0)) u_d (
      .clk(clk), .rst_n(rst_n), .instr_req_i(req), .instr_addr_i(addr),
      .instr_gnt_o(gnt_d), .instr_rvalid_o(rv_d), .instr_rdata_o(rd_d), .instr_err_o(err_d),
      .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata), .busy_o(busy_d));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      req = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      logic [31:0] exp_words [4];
      exp_words[0] = 32'h11; exp_words[1] = 32'h22; exp_words[2] = 32'h33; exp_words[3] = 32'h44;

      rst_n = 1'b0; req = 1'b0; addr = 32'h0;
      ld_we = 1'b0; ld_addr = 12'h0; ld_wdata = 32'h0;
      tick(); tick();

      // reset state, including grant suppression while in reset
      req = 1'b1;
      #1;
      chk("rst_gnt", {31'b0, gnt_a}, 32'd0);
      chk("rst_rvalid", {31'b0, rv_a}, 32'd0);
      chk("rst_rdata", rd_a, 32'd0);
      chk("rst_err", {31'b0, err_a}, 32'd0);
      chk("rst_busy", {31'b0, busy_a}, 32'd0);
      req = 1'b0;
      rst_n = 1'b1;
      tick();

      // loader fills words 0..3 and the last word
      for (int i = 0; i < 4; i++) begin
         ld_we = 1'b1; ld_addr = 12'(i); ld_wdata = exp_words[i];
         tick();
      end
      ld_addr = 12'hFFF; ld_wdata = 32'h5A5A_0FFF;
      tick();
      ld_we = 1'b0;

      // back-to-back fetches, Latency=1, WaitStates=0
      for (int i = 0; i < 5; i++) begin
         req  = (i < 4);
         addr = 32'(4 * i);
         #1;
         chk("b2b_gnt", {31'b0, gnt_a}, (i < 4) ? 32'd1 : 32'd0);
         if (i > 0) begin
            chk("b2b_rvalid", {31'b0, rv_a}, 32'd1);
            chk("b2b_rdata", rd_a, exp_words[i-1]);
            chk("b2b_err", {31'b0, err_a}, 32'd0);
         end
         tick();
      end
      chk("b2b_idle_rvalid", {31'b0, rv_a}, 32'd0);
      chk("b2b_idle_rdata", rd_a, 32'd0);
      idle(4);

      // wait states: two withheld cycles then a grant
      req = 1'b1; addr = 32'h4;
      #1; chk("ws_gnt_c0", {31'b0, gnt_b}, 32'd0); tick();
      #1; chk("ws_gnt_c1", {31'b0, gnt_b}, 32'd0); tick();
      #1; chk("ws_gnt_c2", {31'b0, gnt_b}, 32'd1); tick();
      req = 1'b0;
      #1;
      chk("ws_rvalid", {31'b0, rv_b}, 32'd1);
      chk("ws_rdata", rd_b, 32'h22);
      chk("ws_gnt_after", {31'b0, gnt_b}, 32'd0);
      tick();

      // dropping req mid-wait restarts the count
      req = 1'b1;
      #1; chk("wsr_gnt_a", {31'b0, gnt_b}, 32'd0); tick();
      #1; chk("wsr_gnt_b", {31'b0, gnt_b}, 32'd0); tick();
      req = 1'b0;
      #1; chk("wsr_gnt_drop", {31'b0, gnt_b}, 32'd0); tick();
      req = 1'b1;
      #1; chk("wsr_gnt_r0", {31'b0, gnt_b}, 32'd0); tick();
      #1; chk("wsr_gnt_r1", {31'b0, gnt_b}, 32'd0); tick();
      #1; chk("wsr_gnt_r2", {31'b0, gnt_b}, 32'd1); tick();
      req = 1'b0;
      #1; chk("wsr_rdata", rd_b, 32'h22);
      idle(5);

      // Latency=3 pipelined responses and busy window
      req = 1'b1; addr = 32'h0;
      #1;
      chk("l3_gnt0", {31'b0, gnt_c}, 32'd1);
      chk("l3_busy_g0", {31'b0, busy_c}, 32'd0);
      tick();
      addr = 32'h4;
      #1;
      chk("l3_gnt1", {31'b0, gnt_c}, 32'd1);
      chk("l3_busy_g1", {31'b0, busy_c}, 32'd1);
      tick();
      req = 1'b0;
      #1;
      chk("l3_busy_g2", {31'b0, busy_c}, 32'd1);
      chk("l3_rvalid_g2", {31'b0, rv_c}, 32'd0);
      tick();
      #1;
      chk("l3_rvalid_g3", {31'b0, rv_c}, 32'd1);
      chk("l3_rdata_g3", rd_c, 32'h11);
      chk("l3_busy_g3", {31'b0, busy_c}, 32'd1);
      tick();
      #1;
      chk("l3_rvalid_g4", {31'b0, rv_c}, 32'd1);
      chk("l3_rdata_g4", rd_c, 32'h22);
      chk("l3_busy_g4", {31'b0, busy_c}, 32'd1);
      tick();
      #1;
      chk("l3_rvalid_g5", {31'b0, rv_c}, 32'd0);
      chk("l3_busy_g5", {31'b0, busy_c}, 32'd0);
      idle(4);

      // out-of-range and last in-range word
      req = 1'b1; addr = 32'h0000_4000;
      #1; chk("oor_gnt", {31'b0, gnt_a}, 32'd1); tick();
      addr = 32'h0000_3FFC;
      #1;
      chk("oor_rvalid", {31'b0, rv_a}, 32'd1);
      chk("oor_err", {31'b0, err_a}, 32'd1);
      chk("oor_rdata", rd_a, 32'h0000_0013);
      tick();
      req = 1'b0;
      #1;
      chk("top_rvalid", {31'b0, rv_a}, 32'd1);
      chk("top_err", {31'b0, err_a}, 32'd0);
      chk("top_rdata", rd_a, 32'h5A5A_0FFF);
      idle(5);

      // loader collision: write wins, request granted next cycle with new data
      req = 1'b1; addr = 32'h4;
      ld_we = 1'b1; ld_addr = 12'd1; ld_wdata = 32'hABCD;
      #1; chk("col_gnt_wr", {31'b0, gnt_a}, 32'd0); tick();
      ld_we = 1'b0;
      #1; chk("col_gnt_next", {31'b0, gnt_a}, 32'd1); tick();
      req = 1'b0;
      #1;
      chk("col_rvalid", {31'b0, rv_a}, 32'd1);
      chk("col_rdata", rd_a, 32'hABCD);
      idle(5);

      // reset mid-flight with Latency=2
      req = 1'b1; addr = 32'h8;
      #1; chk("mrst_gnt", {31'b0, gnt_d}, 32'd1); tick();
      req = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", {31'b0, busy_d}, 32'd0);
      chk("mrst_rvalid", {31'b0, rv_d}, 32'd0);
      chk("mrst_rdata", rd_d, 32'd0);
      chk("mrst_gnt_low", {31'b0, gnt_d}, 32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      chk("mrst_no_rv1", {31'b0, rv_d}, 32'd0);
      tick();
      chk("mrst_no_rv2", {31'b0, rv_d}, 32'd0);
      req = 1'b1; addr = 32'hC;
      #1; chk("post_gnt", {31'b0, gnt_d}, 32'd1); tick();
      req = 1'b0;
      #1;
      chk("post_rv_early", {31'b0, rv_d}, 32'd0);
      chk("post_busy", {31'b0, busy_d}, 32'd1);
      tick();
      #1;
      chk("post_rvalid", {31'b0, rv_d}, 32'd1);
      chk("post_rdata", rd_d, 32'h44);
      chk("post_err", {31'b0, err_d}, 32'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
